// File: rtl/rwt_tag_stream_arbiter.sv
// Merges a sample data stream and a tag stream into one escape-flagged output stream.
// Tags get bounded priority over waiting data; tags and escape-colliding data are flagged.
module rwt_tag_stream_arbiter #(
    parameter int DWIDTH        = 64,
    parameter int MAX_TAG_BURST = 4,
    parameter int CWIDTH        = 16
) (
    input  logic              clk,
    input  logic              areset,
    input  logic              enable,
    input  logic [DWIDTH-1:0] tag_escape,
    output logic              s_data_ready,
    input  logic              s_data_valid,
    input  logic [DWIDTH-1:0] s_data_data,
    input  logic              s_data_last,
    output logic              s_tag_ready,
    input  logic              s_tag_valid,
    input  logic [DWIDTH-1:0] s_tag_data,
    input  logic              m_axi_ready,
    output logic              m_axi_valid,
    output logic              m_axi_escape,
    output logic [DWIDTH-1:0] m_axi_data,
    output logic              m_axi_last,
    output logic [CWIDTH-1:0] tag_sent_count,
    output logic [CWIDTH-1:0] tag_drop_count,
    output logic [CWIDTH-1:0] collision_count
);

    localparam int BW = $clog2(MAX_TAG_BURST + 1);
    localparam logic [BW-1:0] BURST_MAX = BW'(MAX_TAG_BURST);

    function automatic logic [CWIDTH-1:0] sat_inc(input logic [CWIDTH-1:0] v);
        if (&v) begin
            return v;
        end else begin
            return v + CWIDTH'(1'b1);
        end
    endfunction

    logic              m_valid_r;
    logic              m_escape_r;
    logic [DWIDTH-1:0] m_data_r;
    logic              m_last_r;
    logic [BW-1:0]     burst_cnt_r;
    logic [CWIDTH-1:0] tag_sent_r;
    logic [CWIDTH-1:0] tag_drop_r;
    logic [CWIDTH-1:0] collision_r;

    logic load_s;
    logic sel_tag_s;
    logic sel_data_s;
    logic collision_s;
    logic drop_s;

    assign load_s      = !m_valid_r | m_axi_ready;
    assign collision_s = (s_data_data == tag_escape);
    assign drop_s      = !enable & s_tag_valid;

    // Source selection: tag first while under the burst limit, then data, then a lone tag.
    always_comb begin
        sel_tag_s  = 1'b0;
        sel_data_s = 1'b0;
        if (enable && s_tag_valid && (burst_cnt_r < BURST_MAX)) begin
            sel_tag_s = 1'b1;
        end else if (s_data_valid) begin
            sel_data_s = 1'b1;
        end else if (enable && s_tag_valid) begin
            sel_tag_s = 1'b1;
        end else begin
            sel_tag_s  = 1'b0;
            sel_data_s = 1'b0;
        end
    end

    // Handshakes are blocked during reset; a disabled tag input always drains.
    assign s_data_ready = !areset & load_s & sel_data_s;
    assign s_tag_ready  = !enable | (!areset & load_s & sel_tag_s);

    // Output word register, held stable while the consumer stalls.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            m_valid_r  <= 1'b0;
            m_escape_r <= 1'b0;
            m_data_r   <= '0;
            m_last_r   <= 1'b0;
        end else if (load_s) begin
            if (sel_tag_s) begin
                m_valid_r  <= 1'b1;
                m_escape_r <= 1'b1;
                m_data_r   <= s_tag_data;
                m_last_r   <= 1'b0;
            end else if (sel_data_s) begin
                m_valid_r  <= 1'b1;
                m_escape_r <= collision_s;
                m_data_r   <= s_data_data;
                m_last_r   <= s_data_last;
            end else begin
                m_valid_r  <= 1'b0;
            end
        end
    end

    // Consecutive-tag counter; any data load reopens the tag window.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            burst_cnt_r <= '0;
        end else if (load_s && sel_tag_s) begin
            if (burst_cnt_r != BURST_MAX) begin
                burst_cnt_r <= burst_cnt_r + BW'(1'b1);
            end
        end else if (load_s && sel_data_s) begin
            burst_cnt_r <= '0;
        end
    end

    // Saturating statistics, updated on the edge of the load or drop they count.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            tag_sent_r  <= '0;
            tag_drop_r  <= '0;
            collision_r <= '0;
        end else begin
            if (load_s && sel_tag_s) begin
                tag_sent_r <= sat_inc(tag_sent_r);
            end
            if (drop_s) begin
                tag_drop_r <= sat_inc(tag_drop_r);
            end
            if (load_s && sel_data_s && collision_s) begin
                collision_r <= sat_inc(collision_r);
            end
        end
    end

    assign m_axi_valid     = m_valid_r;
    assign m_axi_escape    = m_escape_r;
    assign m_axi_data      = m_data_r;
    assign m_axi_last      = m_last_r;
    assign tag_sent_count  = tag_sent_r;
    assign tag_drop_count  = tag_drop_r;
    assign collision_count = collision_r;

endmodule

// File: tb/tb_rwt_tag_stream_arbiter.sv
// Directed, table-driven bench for rwt_tag_stream_arbiter with hand sequences for
// random back-pressure and mid-transfer reset.
module tb_rwt_tag_stream_arbiter;

    localparam logic [63:0] ESC = 64'hDEAD_BEEF_0000_0001;

    logic        clk = 1'b0;
    logic        areset;
    logic        enable;
    logic [63:0] tag_escape;
    logic        s_data_ready;
    logic        s_data_valid;
    logic [63:0] s_data_data;
    logic        s_data_last;
    logic        s_tag_ready;
    logic        s_tag_valid;
    logic [63:0] s_tag_data;
    logic        m_axi_ready;
    logic        m_axi_valid;
    logic        m_axi_escape;
    logic [63:0] m_axi_data;
    logic        m_axi_last;
    logic [3:0]  tag_sent_count;
    logic [3:0]  tag_drop_count;
    logic [3:0]  collision_count;

    int errors = 0;
    int checks = 0;

    rwt_tag_stream_arbiter #(.DWIDTH(64), .MAX_TAG_BURST(4), .CWIDTH(4)) dut (
        .clk(clk), .areset(areset), .enable(enable), .tag_escape(tag_escape),
        .s_data_ready(s_data_ready), .s_data_valid(s_data_valid),
        .s_data_data(s_data_data), .s_data_last(s_data_last),
        .s_tag_ready(s_tag_ready), .s_tag_valid(s_tag_valid), .s_tag_data(s_tag_data),
        .m_axi_ready(m_axi_ready), .m_axi_valid(m_axi_valid), .m_axi_escape(m_axi_escape),
        .m_axi_data(m_axi_data), .m_axi_last(m_axi_last),
        .tag_sent_count(tag_sent_count), .tag_drop_count(tag_drop_count),
        .collision_count(collision_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        dv;
        logic [63:0] dd;
        logic        dl;
        logic        tv;
        logic [63:0] td;
        logic        rdy;
        logic        x_dr;
        logic        x_tr;
        logic        x_v;
        logic        x_e;
        logic [63:0] x_d;
        logic        x_l;
        logic        cc;
        logic [3:0]  x_sent;
        logic [3:0]  x_drop;
        logic [3:0]  x_coll;
    } vec_t;

    vec_t vecs[$];
    int   split;

    function automatic vec_t mk(logic en, logic dv, logic [63:0] dd, logic dl, logic tv,
                                logic [63:0] td, logic rdy, logic xdr, logic xtr, logic xv,
                                logic xe, logic [63:0] xd, logic xl, logic cc,
                                logic [3:0] xs, logic [3:0] xdp, logic [3:0] xc);
        vec_t v;
        v.en = en; v.dv = dv; v.dd = dd; v.dl = dl; v.tv = tv; v.td = td; v.rdy = rdy;
        v.x_dr = xdr; v.x_tr = xtr; v.x_v = xv; v.x_e = xe; v.x_d = xd; v.x_l = xl;
        v.cc = cc; v.x_sent = xs; v.x_drop = xdp; v.x_coll = xc;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        enable       = v.en;
        s_data_valid = v.dv;
        s_data_data  = v.dd;
        s_data_last  = v.dl;
        s_tag_valid  = v.tv;
        s_tag_data   = v.td;
        m_axi_ready  = v.rdy;
        #2;
        chk($sformatf("v%0d s_data_ready", idx), 64'(s_data_ready), 64'(v.x_dr));
        chk($sformatf("v%0d s_tag_ready", idx), 64'(s_tag_ready), 64'(v.x_tr));
        @(posedge clk);
        #1;
        chk($sformatf("v%0d m_axi_valid", idx), 64'(m_axi_valid), 64'(v.x_v));
        if (v.x_v) begin
            chk($sformatf("v%0d m_axi_data", idx), m_axi_data, v.x_d);
            chk($sformatf("v%0d m_axi_escape", idx), 64'(m_axi_escape), 64'(v.x_e));
            chk($sformatf("v%0d m_axi_last", idx), 64'(m_axi_last), 64'(v.x_l));
        end
        if (v.cc) begin
            chk($sformatf("v%0d tag_sent_count", idx), 64'(tag_sent_count), 64'(v.x_sent));
            chk($sformatf("v%0d tag_drop_count", idx), 64'(tag_drop_count), 64'(v.x_drop));
            chk($sformatf("v%0d collision_count", idx), 64'(collision_count), 64'(v.x_coll));
        end
    endtask

    initial begin
        int nt;
        int nd;
        int k;
        int tag_idx;
        int data_idx;
        logic [63:0] exp_d;
        logic        exp_e;
        logic        pv, pr, pe, pl, th, dh;
        logic [63:0] pd;

        // Data only: 0x1..0x8, last on 0x8, then idle.
        for (int i = 1; i <= 8; i++) begin
            vecs.push_back(mk(1'b1, 1'b1, 64'(i), (i == 8), 1'b0, 64'h0, 1'b1,
                              1'b1, 1'b0, 1'b1, 1'b0, 64'(i), (i == 8), (i == 8),
                              4'd0, 4'd0, 4'd0));
        end
        vecs.push_back(mk(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b1,
                          1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0));
        // Both valid continuously: T,T,T,T,D,T,T,T,T,D.
        nt = 0;
        nd = 0;
        for (int c = 0; c < 10; c++) begin
            if ((c % 5) != 4) begin
                vecs.push_back(mk(1'b1, 1'b1, 64'h200 + 64'(nd), 1'b0, 1'b1, 64'h100 + 64'(nt), 1'b1,
                                  1'b0, 1'b1, 1'b1, 1'b1, 64'h100 + 64'(nt), 1'b0, 1'b0,
                                  4'd0, 4'd0, 4'd0));
                nt++;
            end else begin
                vecs.push_back(mk(1'b1, 1'b1, 64'h200 + 64'(nd), 1'b0, 1'b1, 64'h100 + 64'(nt), 1'b1,
                                  1'b1, 1'b0, 1'b1, 1'b0, 64'h200 + 64'(nd), 1'b0, (c == 9),
                                  4'd8, 4'd0, 4'd0));
                nd++;
            end
        end
        // Escape collision on the middle word only.
        vecs.push_back(mk(1'b1, 1'b1, 64'h1, 1'b0, 1'b0, 64'h0, 1'b1,
                          1'b1, 1'b0, 1'b1, 1'b0, 64'h1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0));
        vecs.push_back(mk(1'b1, 1'b1, ESC, 1'b0, 1'b0, 64'h0, 1'b1,
                          1'b1, 1'b0, 1'b1, 1'b1, ESC, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0));
        vecs.push_back(mk(1'b1, 1'b1, 64'h3, 1'b0, 1'b0, 64'h0, 1'b1,
                          1'b1, 1'b0, 1'b1, 1'b0, 64'h3, 1'b0, 1'b1, 4'd8, 4'd0, 4'd1));
        // Disabled: 10 tags dropped alongside data, then tag-only drops saturate at 15.
        for (int i = 0; i < 10; i++) begin
            vecs.push_back(mk(1'b0, 1'b1, 64'h300 + 64'(i), 1'b0, 1'b1, 64'h400 + 64'(i), 1'b1,
                              1'b1, 1'b1, 1'b1, 1'b0, 64'h300 + 64'(i), 1'b0, 1'b1,
                              4'd8, 4'(i + 1), 4'd1));
        end
        for (int j = 0; j < 6; j++) begin
            vecs.push_back(mk(1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 64'h500 + 64'(j), 1'b1,
                              1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1,
                              4'd8, (j < 4) ? 4'(11 + j) : 4'd15, 4'd1));
        end
        // Five-cycle stall mid-packet, a tag slipped in mid-packet, then last.
        vecs.push_back(mk(1'b1, 1'b1, 64'h10, 1'b0, 1'b0, 64'h0, 1'b1,
                          1'b1, 1'b0, 1'b1, 1'b0, 64'h10, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0));
        vecs.push_back(mk(1'b1, 1'b1, 64'h11, 1'b0, 1'b0, 64'h0, 1'b1,
                          1'b1, 1'b0, 1'b1, 1'b0, 64'h11, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0));
        for (int s = 0; s < 5; s++) begin
            vecs.push_back(mk(1'b1, 1'b1, 64'h12, 1'b0, 1'b1, 64'h55, 1'b0,
                              1'b0, 1'b0, 1'b1, 1'b0, 64'h11, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0));
        end
        vecs.push_back(mk(1'b1, 1'b1, 64'h12, 1'b0, 1'b1, 64'h55, 1'b1,
                          1'b0, 1'b1, 1'b1, 1'b1, 64'h55, 1'b0, 1'b1, 4'd9, 4'd15, 4'd1));
        vecs.push_back(mk(1'b1, 1'b1, 64'h12, 1'b0, 1'b0, 64'h0, 1'b1,
                          1'b1, 1'b0, 1'b1, 1'b0, 64'h12, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0));
        vecs.push_back(mk(1'b1, 1'b1, 64'h13, 1'b1, 1'b0, 64'h0, 1'b0,
                          1'b0, 1'b0, 1'b1, 1'b0, 64'h12, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0));
        vecs.push_back(mk(1'b1, 1'b1, 64'h13, 1'b1, 1'b0, 64'h0, 1'b1,
                          1'b1, 1'b0, 1'b1, 1'b0, 64'h13, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0));
        vecs.push_back(mk(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0,
                          1'b0, 1'b0, 1'b1, 1'b0, 64'h13, 1'b1, 1'b0, 4'd0, 4'd0, 4'd0));
        vecs.push_back(mk(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b1,
                          1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 4'd9, 4'd15, 4'd1));
        // Enable falls while a tag is held: the tag is still delivered.
        vecs.push_back(mk(1'b1, 1'b0, 64'h0, 1'b0, 1'b1, 64'h66, 1'b1,
                          1'b0, 1'b1, 1'b1, 1'b1, 64'h66, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0));
        vecs.push_back(mk(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0,
                          1'b0, 1'b1, 1'b1, 1'b1, 64'h66, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0));
        vecs.push_back(mk(1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b1,
                          1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 4'd10, 4'd15, 4'd1));
        vecs.push_back(mk(1'b1, 1'b1, 64'h20, 1'b0, 1'b0, 64'h0, 1'b1,
                          1'b1, 1'b0, 1'b1, 1'b0, 64'h20, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0));
        vecs.push_back(mk(1'b1, 1'b0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b1,
                          1'b0, 1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0));
        split = vecs.size();
        // After reset: burst window starts at zero again.
        for (int c = 0; c < 5; c++) begin
            if (c < 4) begin
                vecs.push_back(mk(1'b1, 1'b1, 64'h800, 1'b0, 1'b1, 64'h700 + 64'(c), 1'b1,
                                  1'b0, 1'b1, 1'b1, 1'b1, 64'h700 + 64'(c), 1'b0, 1'b0,
                                  4'd0, 4'd0, 4'd0));
            end else begin
                vecs.push_back(mk(1'b1, 1'b1, 64'h800, 1'b0, 1'b1, 64'h704, 1'b1,
                                  1'b1, 1'b0, 1'b1, 1'b0, 64'h800, 1'b0, 1'b1,
                                  4'd4, 4'd0, 4'd0));
            end
        end

        // Reset state.
        tag_escape   = ESC;
        areset       = 1'b1;
        enable       = 1'b1;
        s_data_valid = 1'b1;
        s_data_data  = 64'h0;
        s_data_last  = 1'b0;
        s_tag_valid  = 1'b1;
        s_tag_data   = 64'h0;
        m_axi_ready  = 1'b1;
        #1;
        chk("reset m_axi_valid", 64'(m_axi_valid), 64'h0);
        chk("reset m_axi_data", m_axi_data, 64'h0);
        chk("reset s_data_ready", 64'(s_data_ready), 64'h0);
        chk("reset s_tag_ready en1", 64'(s_tag_ready), 64'h0);
        enable = 1'b0;
        #1;
        chk("reset s_tag_ready en0", 64'(s_tag_ready), 64'h1);
        enable       = 1'b1;
        s_data_valid = 1'b0;
        s_tag_valid  = 1'b0;
        @(posedge clk);
        #1;
        areset = 1'b0;

        for (int i = 0; i < split; i++) begin
            apply(vecs[i], i);
        end

        // Random back-pressure with both sources always valid; order stays T,T,T,T,D.
        k        = 0;
        tag_idx  = 0;
        data_idx = 0;
        for (int c = 0; c < 300; c++) begin
            enable       = 1'b1;
            s_tag_valid  = 1'b1;
            s_data_valid = 1'b1;
            s_data_last  = 1'b0;
            s_tag_data   = 64'h1000 + 64'(tag_idx);
            s_data_data  = 64'h2000 + 64'(data_idx);
            m_axi_ready  = (c >= 60 && c < 65) ? 1'b0 : ($urandom_range(0, 1) == 1);
            #2;
            chk($sformatf("rnd%0d one ready", c), 64'(s_data_ready & s_tag_ready), 64'h0);
            if (m_axi_valid && m_axi_ready) begin
                if ((k % 5) == 4) begin
                    exp_d = 64'h2000 + 64'(k / 5);
                    exp_e = 1'b0;
                end else begin
                    exp_d = 64'h1000 + 64'(k - k / 5);
                    exp_e = 1'b1;
                end
                chk($sformatf("rnd word%0d data", k), m_axi_data, exp_d);
                chk($sformatf("rnd word%0d escape", k), 64'(m_axi_escape), 64'(exp_e));
                k++;
            end
            pv = m_axi_valid;
            pr = m_axi_ready;
            pd = m_axi_data;
            pe = m_axi_escape;
            pl = m_axi_last;
            th = s_tag_ready;
            dh = s_data_ready;
            @(posedge clk);
            #1;
            if (pv && !pr) begin
                chk($sformatf("rnd%0d stall hold", c), {m_axi_data[60:0], m_axi_valid, m_axi_escape, m_axi_last},
                    {pd[60:0], 1'b1, pe, pl});
            end
            if (th) tag_idx++;
            if (dh) data_idx++;
        end
        chk("rnd words accepted >= 50", 64'(k >= 50), 64'h1);
        chk("tag_sent_count saturated", 64'(tag_sent_count), 64'hF);

        // Reset pulsed while a word is held.
        s_tag_valid  = 1'b1;
        s_data_valid = 1'b1;
        m_axi_ready  = 1'b0;
        @(posedge clk);
        #2;
        chk("pre-reset m_axi_valid", 64'(m_axi_valid), 64'h1);
        areset = 1'b1;
        #1;
        chk("mid reset m_axi_valid", 64'(m_axi_valid), 64'h0);
        chk("mid reset m_axi_escape", 64'(m_axi_escape), 64'h0);
        chk("mid reset m_axi_last", 64'(m_axi_last), 64'h0);
        chk("mid reset m_axi_data", m_axi_data, 64'h0);
        chk("mid reset counters", {52'h0, tag_sent_count, tag_drop_count, collision_count}, 64'h0);
        chk("mid reset s_data_ready", 64'(s_data_ready), 64'h0);
        chk("mid reset s_tag_ready", 64'(s_tag_ready), 64'h0);
        m_axi_ready  = 1'b1;
        s_tag_valid  = 1'b0;
        s_data_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("held reset m_axi_valid", 64'(m_axi_valid), 64'h0);
        areset = 1'b0;

        for (int i = split; i < vecs.size(); i++) begin
            apply(vecs[i], i);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
